gps_frame_scheduler: RTL and testbench

- Sits between the GPS acquisition unit (224-bit parsed GPS_DATA word plus ERROR flag) and a byte-wide downstream sink, such as a host UART TX or telemetry FIFO.
- Detects each new parsed fix, snapshots it, and schedules transmission of a framed, checksummed 31-byte packet over a valid/ready byte stream.
- Runs a loss-of-fix watchdog that forces periodic heartbeat frames with a lost flag when the GPS stops updating.

---
 rtl/gps_frame_scheduler.sv | 176 +++++++++++++++++
 tb/tb_gps_frame_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_frame_scheduler.sv
// Snapshots each new parsed GPS fix and streams it as a 31-byte framed, checksummed packet
// over a valid/ready byte interface, with a loss-of-fix watchdog that forces heartbeat frames.
module gps_frame_scheduler #(
    parameter int unsigned DATA_W         = 224,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] gps_data,
    input  logic              gps_error,
    input  logic              enable,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_busy,
    output logic              gps_lost,
    output logic [7:0]        overrun_count
);

    localparam int unsigned NUM_BYTES = DATA_W / 8;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned WD_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        FLAGS,
        DATA,
        CSUM
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] shadow, shadow_n;
    logic [DATA_W-1:0] tx_buf, tx_buf_n;
    logic [DATA_W-1:0] tx_shift;
    logic [7:0]        flags, flags_n;
    logic [7:0]        csum, csum_n;
    logic [IDX_W-1:0]  byte_idx, byte_idx_n;
    logic [WD_W-1:0]   watchdog, watchdog_n;
    logic              pending, pending_n;
    logic [7:0]        out_data_n;
    logic              out_valid_n;
    logic              frame_busy_n;
    logic              gps_lost_n;
    logic [7:0]        overrun_n;

    logic changed;
    logic timeout;
    logic xfer;
    logic consume;

    // Change detect, watchdog, frame sequencing; all outputs come from next-state values.
    always_comb begin
        state_n      = state;
        shadow_n     = shadow;
        tx_buf_n     = tx_buf;
        flags_n      = flags;
        csum_n       = csum;
        byte_idx_n   = byte_idx;
        watchdog_n   = watchdog;
        pending_n    = pending;
        out_data_n   = out_data;
        gps_lost_n   = gps_lost;
        overrun_n    = overrun_count;

        changed  = (gps_data != shadow);
        timeout  = !changed && (watchdog == WD_W'(TIMEOUT_CYCLES - 1));
        xfer     = out_valid && out_ready;
        consume  = (state == IDLE) && pending && enable;
        tx_shift = tx_buf << 8;

        // A snapshot taken this cycle uses the old shadow, so a simultaneous set is not a drop.
        if (consume) begin
            pending_n = 1'b0;
        end
        if (changed || timeout) begin
            if (pending && !consume && (overrun_count != 8'hFF)) begin
                overrun_n = overrun_count + 8'd1;
            end
            pending_n  = 1'b1;
            watchdog_n = '0;
            gps_lost_n = timeout;
        end else begin
            watchdog_n = watchdog + WD_W'(1);
        end
        if (changed) begin
            shadow_n = gps_data;
        end

        case (state)
            IDLE: begin
                if (consume) begin
                    state_n    = SYNC;
                    tx_buf_n   = shadow;
                    flags_n    = {6'b0, gps_lost, gps_error};
                    csum_n     = flags_n;
                    out_data_n = SYNC_BYTE;
                end
            end
            SYNC: begin
                if (xfer) begin
                    state_n    = FLAGS;
                    out_data_n = flags;
                end
            end
            FLAGS: begin
                if (xfer) begin
                    state_n    = DATA;
                    byte_idx_n = '0;
                    out_data_n = tx_buf[DATA_W-1 -: 8];
                end
            end
            DATA: begin
                if (xfer) begin
                    csum_n   = csum ^ out_data;
                    tx_buf_n = tx_shift;
                    if (byte_idx == IDX_W'(NUM_BYTES - 1)) begin
                        state_n    = CSUM;
                        out_data_n = csum_n;
                    end else begin
                        byte_idx_n = byte_idx + IDX_W'(1);
                        out_data_n = tx_shift[DATA_W-1 -: 8];
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_n    = IDLE;
                    out_data_n = 8'h00;
                end
            end
            default: begin
                state_n    = IDLE;
                out_data_n = 8'h00;
            end
        endcase

        out_valid_n  = (state_n != IDLE);
        frame_busy_n = (state_n != IDLE);
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            shadow        <= '0;
            tx_buf        <= '0;
            flags         <= '0;
            csum          <= '0;
            byte_idx      <= '0;
            watchdog      <= '0;
            pending       <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            frame_busy    <= 1'b0;
            gps_lost      <= 1'b0;
            overrun_count <= '0;
        end else begin
            state         <= state_n;
            shadow        <= shadow_n;
            tx_buf        <= tx_buf_n;
            flags         <= flags_n;
            csum          <= csum_n;
            byte_idx      <= byte_idx_n;
            watchdog      <= watchdog_n;
            pending       <= pending_n;
            out_data      <= out_data_n;
            out_valid     <= out_valid_n;
            frame_busy    <= frame_busy_n;
            gps_lost      <= gps_lost_n;
            overrun_count <= overrun_n;
        end
    end

endmodule

// File: tb/tb_gps_frame_scheduler.sv
// Bench for gps_frame_scheduler: directed scenarios plus random traffic, checked every cycle
// against a frame-level behavioural model.
module tb_gps_frame_scheduler;

    localparam int unsigned DW = 224;
    localparam int unsigned TO = 100;
    typedef logic [7:0] byte_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] gps_data = '0;
    logic          gps_error = 1'b0;
    logic          enable = 1'b1;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          frame_busy;
    logic          gps_lost;
    logic [7:0]    overrun_count;

    gps_frame_scheduler #(
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TO),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .gps_data(gps_data),
        .gps_error(gps_error),
        .enable(enable),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_busy(frame_busy),
        .gps_lost(gps_lost),
        .overrun_count(overrun_count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    byte_t got[$];

    // Model state: what the sink should see, expressed as whole frames.
    logic [DW-1:0] m_shadow = '0;
    bit            m_pending = 0;
    int            m_wd = 0;
    bit            m_lost = 0;
    int            m_ovr = 0;
    bit            m_active = 0;
    int            m_pos = 0;
    logic [DW-1:0] m_fdata = '0;
    byte_t         m_fflags = 8'h00;

    function automatic byte_t frame_byte(input logic [DW-1:0] d, input byte_t fl, input int i);
        byte_t cs;
        if (i == 0) return 8'hA5;
        if (i == 1) return fl;
        if (i <= 29) return d[DW-1-8*(i-2) -: 8];
        cs = fl;
        for (int k = 0; k < 28; k++) cs = cs ^ d[DW-1-8*k -: 8];
        return cs;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < 7; i++) w = (w << 32) | DW'($urandom());
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        bit ch, to, cons, pend_old;
        if (reset) begin
            m_shadow = '0; m_pending = 0; m_wd = 0; m_lost = 0; m_ovr = 0;
            m_active = 0; m_pos = 0;
        end else begin
            pend_old = m_pending;
            cons = !m_active && m_pending && enable;
            if (m_active && out_ready) begin
                m_pos++;
                if (m_pos == 31) m_active = 0;
            end
            if (cons) begin
                m_fdata = m_shadow;
                m_fflags = {6'b0, m_lost, gps_error};
                m_active = 1;
                m_pos = 0;
                m_pending = 0;
            end
            ch = (gps_data != m_shadow);
            to = !ch && (m_wd == TO - 1);
            if (ch || to) begin
                if (pend_old && !cons && m_ovr < 255) m_ovr++;
                m_pending = 1;
                m_wd = 0;
                m_lost = to;
            end else begin
                m_wd++;
            end
            if (ch) m_shadow = gps_data;
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(m_active));
        chk("frame_busy", 32'(frame_busy), 32'(m_active));
        chk("gps_lost", 32'(gps_lost), 32'(m_lost));
        chk("overrun_count", 32'(overrun_count), 32'(m_ovr));
        if (m_active) chk("out_data", 32'(out_data), 32'(frame_byte(m_fdata, m_fflags, m_pos)));
    endtask

    task automatic step();
        if (out_valid && out_ready) got.push_back(out_data);
        @(posedge clock);
        model_edge();
        cyc++;
        #1;
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_frame1(input string tag, input int base);
        chk({tag, "_sync"}, 32'(got[base]), 32'h000000A5);
        chk({tag, "_flags"}, 32'(got[base+1]), 32'h00000000);
        for (int k = 0; k < 28; k++) chk({tag, "_data"}, 32'(got[base+2+k]), 32'(k + 1));
        chk({tag, "_csum"}, 32'(got[base+30]), 32'h0000001C);
    endtask

    logic [DW-1:0] d1;
    logic [DW-1:0] last;
    int chg_edge, lost_edge, n;
    bit seen;

    initial begin
        for (int k = 0; k < 28; k++) d1[DW-1-8*k -: 8] = byte_t'(k + 1);

        // Reset state
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_overrun", 32'(overrun_count), 0);
        chk("rst_lost", 32'(gps_lost), 0);

        // Basic frame with ready held high
        reset = 1'b0; gps_data = d1; got.delete();
        steps(40);
        chk("f1_len", 32'(got.size()), 31);
        if (got.size() >= 31) chk_frame1("f1", 0);
        chk("f1_overrun", 32'(overrun_count), 0);
        chk("f1_busy_after", 32'(frame_busy), 0);

        // Same frame, ready toggling every cycle
        do_reset(); got.delete();
        for (int i = 0; i < 70; i++) begin out_ready = ~out_ready; step(); end
        chk("f2_len", 32'(got.size()), 31);
        if (got.size() >= 31) chk_frame1("f2", 0);
        out_ready = 1'b1;

        // Reset pulse mid-frame
        do_reset(); got.delete();
        for (int i = 0; i < 40 && got.size() < 10; i++) step();
        reset = 1'b1; gps_data = '0;
        step();
        reset = 1'b0;
        n = got.size();
        chk("abort_valid", 32'(out_valid), 0);
        steps(30);
        chk("abort_no_resume", 32'(got.size()), 32'(n));

        // Three updates during a frame coalesce into one follow-up frame
        do_reset(); gps_data = d1; got.delete();
        steps(6);
        for (int j = 0; j < 3; j++) begin
            chg_edge = cyc + 1;
            gps_data = rnd_word();
            step();
        end
        last = gps_data;
        steps(70);
        chk("coal_overrun", 32'(overrun_count), 2);
        chk("coal_len", 32'(got.size()), 62);
        if (got.size() >= 62) begin
            chk_frame1("coal_f1", 0);
            for (int i = 0; i < 31; i++) chk("coal_f2", 32'(got[31+i]), 32'(frame_byte(last, 8'h00, i)));
        end

        // Watchdog expiry and heartbeats
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin step(); seen = gps_lost; end
        lost_edge = cyc;
        chk("lost_seen", 32'(seen), 1);
        chk("lost_delay", 32'(lost_edge - chg_edge), 100);
        got.delete();
        steps(35);
        chk("hb_len", 32'(got.size()), 31);
        if (got.size() >= 2) begin
            chk("hb_sync", 32'(got[0]), 32'h000000A5);
            chk("hb_flags", 32'(got[1]), 32'h00000002);
        end
        seen = 0;
        for (int i = 0; i < 150 && !seen; i++) begin step(); seen = out_valid; end
        chk("hb_period", 32'(cyc), 32'(lost_edge + 101));
        steps(35);
        gps_error = 1'b1; gps_data = rnd_word();
        step();
        chk("lost_cleared", 32'(gps_lost), 0);
        got.delete();
        steps(40);
        chk("err_len", 32'(got.size()), 31);
        if (got.size() >= 2) chk("err_flags", 32'(got[1]), 32'h00000001);
        gps_error = 1'b0;

        // Enable gating
        enable = 1'b0; got.delete();
        gps_data = rnd_word();
        steps(20);
        chk("en_hold_valid", 32'(out_valid), 0);
        chk("en_hold_len", 32'(got.size()), 0);
        enable = 1'b1;
        step();
        chk("en_start", 32'(out_valid), 1);
        for (int i = 0; i < 20 && got.size() < 5; i++) step();
        enable = 1'b0;
        steps(40);
        chk("en_drop_len", 32'(got.size()), 31);
        enable = 1'b1;

        // Overrun saturation with a stalled sink
        do_reset(); out_ready = 1'b0; gps_data = d1;
        steps(2);
        for (int i = 0; i < 300; i++) begin gps_data = d1 ^ DW'(i + 1); step(); end
        chk("ovr_sat", 32'(overrun_count), 255);
        out_ready = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) < ((i < 1500) ? 30 : 3)) gps_data = rnd_word();
            out_ready = ($urandom_range(99) < 70);
            enable = ($urandom_range(99) < 90);
            if ($urandom_range(99) < 5) gps_error = ~gps_error;
            reset = ($urandom_range(999) < 2);
            step();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
